eth_mac_tx_arb: RTL and testbench

Frame-atomic round-robin arbiter that shares the Ethernet MAC direct TX data path (tx_valid/tx_data/tx_start/tx_end/tx_bytesel/tx_ready plus TX status) between two 32-bit frame sources. It sits in the application clock domain, between the user TX sources and the MAC top's direct-access TX port. That port is only live when the MAC top is built with DATA_ACCESS_USE_MCU = 0. Each per-frame TX status word returned by the MAC is routed back to the source that sent the frame.

---
 rtl/eth_mac_tx_arb.sv | 216 +++++++++++++++++++++
 tb/tb_eth_mac_tx_arb.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_mac_tx_arb.sv
// -----------------------------------------------------------------------------
// eth_mac_tx_arb
//
// Frame-atomic round-robin arbiter that shares the MAC direct TX data path
// between two 32-bit frame sources. A source is granted only on a start beat.
// It keeps the path until its end beat is accepted. The id of every frame
// handed to the MAC is queued, so that each TX status word coming back from
// the MAC is routed to the source that sent that frame.
//
// Ports
//   clk_app_i, rst_clk_app_n          application clock, async active-low reset
//   sN_valid/data/start/end/bytesel_i source N beat (N = 0, 1)
//   sN_ready_o                        source N beat accepted (valid & ready)
//   sN_status_o, sN_status_valid_o    routed TX status word + one-cycle pulse
//   tx_valid/data/start/end/bytesel_o beat towards the MAC
//   tx_ready_i                        MAC accepts the beat
//   tx_status_i, tx_status_valid_i    per-frame TX status from the MAC
//   owner_o                           {busy, owner id}, 2'b00 when idle
//   err_orphan_o                      sticky: status with no frame outstanding
//   err_proto_o                       sticky: non-start beat flushed while idle
// -----------------------------------------------------------------------------
module eth_mac_tx_arb #(
  parameter int STAT_DEPTH = 4
) (
  input  logic        clk_app_i,
  input  logic        rst_clk_app_n,
  input  logic        s0_valid_i,
  input  logic [31:0] s0_data_i,
  input  logic        s0_start_i,
  input  logic        s0_end_i,
  input  logic [1:0]  s0_bytesel_i,
  output logic        s0_ready_o,
  output logic [7:0]  s0_status_o,
  output logic        s0_status_valid_o,
  input  logic        s1_valid_i,
  input  logic [31:0] s1_data_i,
  input  logic        s1_start_i,
  input  logic        s1_end_i,
  input  logic [1:0]  s1_bytesel_i,
  output logic        s1_ready_o,
  output logic [7:0]  s1_status_o,
  output logic        s1_status_valid_o,
  output logic        tx_valid_o,
  output logic [31:0] tx_data_o,
  output logic        tx_start_o,
  output logic        tx_end_o,
  output logic [1:0]  tx_bytesel_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  tx_status_i,
  input  logic        tx_status_valid_i,
  output logic [1:0]  owner_o,
  output logic        err_orphan_o,
  output logic        err_proto_o
);

  localparam int PTR_W = (STAT_DEPTH > 1) ? $clog2(STAT_DEPTH) : 1;
  localparam int CNT_W = $clog2(STAT_DEPTH + 1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t             state_reg;
  logic               owner_reg;
  logic               pri_reg;
  logic               fifo_mem [STAT_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   cnt_next;
  logic [7:0]         status_reg [2];
  logic [1:0]         status_valid_reg;
  logic               err_orphan_reg;
  logic               err_proto_reg;

  // Source inputs gathered into arrays indexed by source id
  logic [1:0]  src_valid;
  logic [1:0]  src_start;
  logic [1:0]  src_end;
  logic [31:0] src_data [2];
  logic [1:0]  src_bytesel [2];
  logic [1:0]  src_ready;

  assign src_valid      = {s1_valid_i, s0_valid_i};
  assign src_start      = {s1_start_i, s0_start_i};
  assign src_end        = {s1_end_i, s0_end_i};
  assign src_data[0]    = s0_data_i;
  assign src_data[1]    = s1_data_i;
  assign src_bytesel[0] = s0_bytesel_i;
  assign src_bytesel[1] = s1_bytesel_i;

  logic       busy;
  logic [1:0] cand;
  logic [1:0] junk;
  logic       fifo_full;
  logic       fifo_empty;
  logic       grant;
  logic       grant_id;
  logic       push;
  logic       pop;
  logic       bypass;
  logic       route;
  logic       route_id;
  logic       orphan;
  logic       do_write;
  logic       do_read;

  assign busy       = (state_reg == XFER);
  assign cand       = src_valid & src_start;
  assign junk       = src_valid & ~src_start;
  assign fifo_full  = (cnt_reg == CNT_W'(STAT_DEPTH));
  assign fifo_empty = (cnt_reg == '0);
  assign grant      = ~busy & (|cand) & ~fifo_full;
  // With both requesting, pri names the winner. Otherwise the single requester wins.
  assign grant_id   = (cand[0] & cand[1]) ? pri_reg : cand[1];

  // Owner's beat goes straight through to the MAC. The path is all-zero while idle.
  assign tx_valid_o   = busy & src_valid[owner_reg];
  assign tx_data_o    = busy ? src_data[owner_reg] : 32'd0;
  assign tx_start_o   = busy & src_start[owner_reg];
  assign tx_end_o     = busy & src_end[owner_reg];
  assign tx_bytesel_o = busy ? src_bytesel[owner_reg] : 2'b00;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      // While idle, any non-start beat is swallowed and discarded. Ready is held low in reset.
      assign src_ready[gi] = rst_clk_app_n &
                             (busy ? ((owner_reg == 1'(gi)) & tx_ready_i) : junk[gi]);
    end
  endgenerate

  assign s0_ready_o = src_ready[0];
  assign s1_ready_o = src_ready[1];

  // Status routing. When the FIFO is empty and a frame ends in the same cycle,
  // the finishing owner's id goes straight to the router and is never stored.
  assign push     = tx_valid_o & tx_ready_i & tx_end_o;
  assign pop      = tx_status_valid_i;
  assign bypass   = pop & fifo_empty & push;
  assign route    = pop & (~fifo_empty | push);
  assign route_id = fifo_empty ? owner_reg : fifo_mem[rd_ptr_reg];
  assign orphan   = pop & fifo_empty & ~push;
  assign do_write = push & ~bypass;
  assign do_read  = pop & ~fifo_empty;
  assign cnt_next = cnt_reg + CNT_W'(do_write) - CNT_W'(do_read);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(STAT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      pri_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant) begin
            state_reg <= XFER;
            owner_reg <= grant_id;
          end
        end
        XFER: begin
          if (push) begin
            state_reg <= IDLE;
            pri_reg   <= ~owner_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (do_write) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_read)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      cnt_reg <= cnt_next;
    end
  end

  // Entry storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_app_i) begin
    if (do_write) fifo_mem[wr_ptr_reg] <= owner_reg;
  end

  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      status_reg[0]    <= 8'd0;
      status_reg[1]    <= 8'd0;
      status_valid_reg <= 2'b00;
      err_orphan_reg   <= 1'b0;
      err_proto_reg    <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        status_valid_reg[i] <= route & (route_id == 1'(i));
        if (route && (route_id == 1'(i))) status_reg[i] <= tx_status_i;
      end
      if (orphan)          err_orphan_reg <= 1'b1;
      if (!busy && |junk)  err_proto_reg  <= 1'b1;
    end
  end

  assign s0_status_o       = status_reg[0];
  assign s1_status_o       = status_reg[1];
  assign s0_status_valid_o = status_valid_reg[0];
  assign s1_status_valid_o = status_valid_reg[1];
  assign owner_o           = {busy, busy & owner_reg};
  assign err_orphan_o      = err_orphan_reg;
  assign err_proto_o       = err_proto_reg;

endmodule

// File: tb/tb_eth_mac_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_eth_mac_tx_arb
//
// Drives two frame sources, MAC ready and MAC status with directed and random
// traffic. Every cycle, all DUT outputs are compared against a frame-level
// reference model. The model tracks busy/owner/pointer and keeps a queue of
// frame ids awaiting status.
// -----------------------------------------------------------------------------
module tb_eth_mac_tx_arb;
  localparam int SD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        s_valid [2];
  logic        s_start [2];
  logic        s_end   [2];
  logic [31:0] s_data  [2];
  logic [1:0]  s_bsel  [2];
  logic        s0_ready, s1_ready, s0_sv, s1_sv;
  logic [7:0]  s0_status, s1_status;
  logic        tx_valid, tx_start, tx_end, tx_ready, tx_status_valid;
  logic [31:0] tx_data;
  logic [1:0]  tx_bsel, owner;
  logic [7:0]  tx_status;
  logic        err_orphan, err_proto;

  eth_mac_tx_arb #(.STAT_DEPTH(SD)) dut (
    .clk_app_i(clk), .rst_clk_app_n(rst_n),
    .s0_valid_i(s_valid[0]), .s0_data_i(s_data[0]), .s0_start_i(s_start[0]),
    .s0_end_i(s_end[0]), .s0_bytesel_i(s_bsel[0]), .s0_ready_o(s0_ready),
    .s0_status_o(s0_status), .s0_status_valid_o(s0_sv),
    .s1_valid_i(s_valid[1]), .s1_data_i(s_data[1]), .s1_start_i(s_start[1]),
    .s1_end_i(s_end[1]), .s1_bytesel_i(s_bsel[1]), .s1_ready_o(s1_ready),
    .s1_status_o(s1_status), .s1_status_valid_o(s1_sv),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_start_o(tx_start),
    .tx_end_o(tx_end), .tx_bytesel_o(tx_bsel), .tx_ready_i(tx_ready),
    .tx_status_i(tx_status), .tx_status_valid_i(tx_status_valid),
    .owner_o(owner), .err_orphan_o(err_orphan), .err_proto_o(err_proto)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit         m_busy, m_owner, m_pri, m_orphan, m_proto;
  bit         m_q[$];
  logic [7:0] m_stat [2];
  bit         m_sv [2];

  // Source driver state
  int frames_left [2];
  int beat_idx [2];
  int fr_len [2];
  int len_fixed [2];
  bit junk_req [2];
  int pv, pr, ps, pj;
  int rdy_q[$];
  int st_q[$];
  logic [1:0] own_log[$];
  bit last_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit rnd_pct(input int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  task automatic drive();
    int v;
    for (int i = 0; i < 2; i++) begin
      if (!junk_req[i] && beat_idx[i] == 0 && pj > 0 && !(m_busy && m_owner == 1'(i)) && rnd_pct(pj))
        junk_req[i] = 1'b1;
      if (junk_req[i]) begin
        s_valid[i] = 1'b1; s_start[i] = 1'b0; s_end[i] = 1'b0;
        s_data[i] = $urandom; s_bsel[i] = 2'($urandom);
      end else if (frames_left[i] > 0) begin
        if (fr_len[i] == 0) fr_len[i] = (len_fixed[i] > 0) ? len_fixed[i] : int'($urandom_range(1, 6));
        s_valid[i] = rnd_pct(pv);
        s_start[i] = (beat_idx[i] == 0);
        s_end[i]   = (beat_idx[i] == fr_len[i] - 1);
        s_data[i]  = $urandom;
        s_bsel[i]  = 2'($urandom);
      end else begin
        s_valid[i] = 1'b0; s_start[i] = 1'b0; s_end[i] = 1'b0;
        s_data[i] = 32'd0; s_bsel[i] = 2'b00;
      end
    end
    if (rdy_q.size() > 0) tx_ready = (rdy_q.pop_front() != 0);
    else tx_ready = rnd_pct(pr);
    if (st_q.size() > 0) begin
      v = st_q.pop_front();
      tx_status_valid = (v >= 0);
      tx_status = (v >= 0) ? 8'(v) : 8'd0;
    end else begin
      tx_status_valid = rnd_pct(ps);
      tx_status = 8'($urandom);
    end
  endtask

  // Compare every output with the model, then advance the model by one clock.
  task automatic model_step();
    bit er [2];
    bit etv, ets, ete, o, push, bypass, rt, id, c0, c1;
    logic [31:0] ed;
    logic [1:0] eb, eo;
    int qsz;
    o = m_owner;
    er[0] = 1'b0; er[1] = 1'b0;
    etv = 0; ets = 0; ete = 0; ed = '0; eb = '0;
    if (m_busy) begin
      etv = s_valid[o]; ed = s_data[o]; ets = s_start[o]; ete = s_end[o]; eb = s_bsel[o];
      er[o] = tx_ready;
    end else begin
      for (int i = 0; i < 2; i++) er[i] = s_valid[i] && !s_start[i];
    end
    eo = m_busy ? {1'b1, o} : 2'b00;
    chk("tx_valid", 32'(tx_valid), 32'(etv));
    chk("tx_data", tx_data, ed);
    chk("tx_start", 32'(tx_start), 32'(ets));
    chk("tx_end", 32'(tx_end), 32'(ete));
    chk("tx_bytesel", 32'(tx_bsel), 32'(eb));
    chk("s0_ready", 32'(s0_ready), 32'(er[0]));
    chk("s1_ready", 32'(s1_ready), 32'(er[1]));
    chk("owner", 32'(owner), 32'(eo));
    chk("s0_status", 32'(s0_status), 32'(m_stat[0]));
    chk("s1_status", 32'(s1_status), 32'(m_stat[1]));
    chk("s0_status_valid", 32'(s0_sv), 32'(m_sv[0]));
    chk("s1_status_valid", 32'(s1_sv), 32'(m_sv[1]));
    chk("err_orphan", 32'(err_orphan), 32'(m_orphan));
    chk("err_proto", 32'(err_proto), 32'(m_proto));
    if (owner[1] && !last_busy) own_log.push_back(owner);
    last_busy = owner[1];

    qsz = m_q.size();
    push = m_busy && s_valid[o] && tx_ready && s_end[o];
    bypass = 0; rt = 0; id = 0;
    m_sv[0] = 0; m_sv[1] = 0;
    if (tx_status_valid) begin
      if (qsz > 0) begin id = m_q.pop_front(); rt = 1; end
      else if (push) begin id = o; rt = 1; bypass = 1; end
      else m_orphan = 1;
    end
    if (rt) begin
      m_stat[id] = tx_status; m_sv[id] = 1;
      $display("status -> src=%0d val=%02h t=%0t", id, tx_status, $time);
    end
    if (push && !bypass) m_q.push_back(o);
    if (!m_busy && (er[0] || er[1])) m_proto = 1;
    if (m_busy) begin
      if (push) begin
        m_busy = 0; m_pri = !o;
        $display("frame done src=%0d t=%0t", o, $time);
      end
    end else begin
      c0 = s_valid[0] && s_start[0];
      c1 = s_valid[1] && s_start[1];
      if ((c0 || c1) && qsz < SD) begin
        m_busy = 1;
        m_owner = (c0 && c1) ? m_pri : c1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (s_valid[i] && er[i]) begin
        if (junk_req[i]) junk_req[i] = 0;
        else if (s_end[i]) begin
          beat_idx[i] = 0; fr_len[i] = 0; frames_left[i]--;
        end else beat_idx[i]++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    model_step();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid[i] = 0; s_start[i] = 0; s_end[i] = 0; s_data[i] = '0; s_bsel[i] = '0;
      frames_left[i] = 0; beat_idx[i] = 0; fr_len[i] = 0; len_fixed[i] = 0; junk_req[i] = 0;
      m_stat[i] = 8'd0; m_sv[i] = 0;
    end
    tx_ready = 0; tx_status_valid = 0; tx_status = '0;
    m_busy = 0; m_owner = 0; m_pri = 0; m_orphan = 0; m_proto = 0;
    m_q.delete(); rdy_q.delete(); st_q.delete(); own_log.delete();
    last_busy = 0;
    pv = 100; pr = 100; ps = 0; pj = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int maxc, input string tag);
    int n;
    bit to;
    n = 0;
    while ((frames_left[0] > 0 || frames_left[1] > 0 || junk_req[0] || junk_req[1] || m_busy) && n < maxc) begin
      step();
      n++;
    end
    to = (n >= maxc);
    chk(tag, 32'(to), 32'd0);
  endtask

  initial begin
    logic [1:0] exp_seq [3];
    int n;
    exp_seq[0] = 2'b10; exp_seq[1] = 2'b11; exp_seq[2] = 2'b10;

    // Single frame from s0, then its status
    reset_dut();
    frames_left[0] = 1; len_fixed[0] = 4;
    drain(30, "t1_drain");
    st_q.push_back(8'h5A);
    step(); step();
    chk("t1_s0_status", 32'(s0_status), 32'h5A);
    chk("t1_s0_pulse", 32'(s0_sv), 32'd1);
    chk("t1_s1_pulse", 32'(s1_sv), 32'd0);

    // Simultaneous requests, three rounds
    reset_dut();
    frames_left[0] = 2; frames_left[1] = 1; len_fixed[0] = 3; len_fixed[1] = 3;
    repeat (20) step();
    st_q.push_back(8'h11); st_q.push_back(8'h22);
    drain(40, "t2_drain");
    st_q.push_back(8'h33);
    repeat (3) step();
    chk("t2_grants", 32'(own_log.size()), 32'd3);
    for (int k = 0; k < own_log.size() && k < 3; k++) chk("t2_owner_seq", 32'(own_log[k]), 32'(exp_seq[k]));
    chk("t2_s0_status", 32'(s0_status), 32'h33);
    chk("t2_s1_status", 32'(s1_status), 32'h22);

    // Backpressure with a waiting non-owner
    reset_dut();
    frames_left[0] = 1; len_fixed[0] = 4; frames_left[1] = 1; len_fixed[1] = 2;
    rdy_q.push_back(1); rdy_q.push_back(1); rdy_q.push_back(0); rdy_q.push_back(0); rdy_q.push_back(1);
    drain(40, "t3_drain");

    // Status FIFO full blocks the next grant until a pop
    reset_dut();
    frames_left[0] = 1; len_fixed[0] = 2;
    drain(20, "t4_drain_a");
    frames_left[1] = 1; len_fixed[1] = 2;
    drain(20, "t4_drain_b");
    frames_left[0] = 1;
    repeat (5) step();
    chk("t4_hold_owner", 32'(owner), 32'd0);
    chk("t4_hold_ready", 32'(s0_ready), 32'd0);
    st_q.push_back(8'hA1);
    step(); step();
    chk("t4_after_pop", 32'(owner), 32'd0);
    step();
    chk("t4_grant", 32'(owner), 32'h2);
    drain(20, "t4_drain_c");

    // Error flags
    reset_dut();
    st_q.push_back(8'h77);
    step(); step();
    chk("t5_orphan", 32'(err_orphan), 32'd1);
    chk("t5_no_pulse0", 32'(s0_sv), 32'd0);
    chk("t5_no_pulse1", 32'(s1_sv), 32'd0);
    junk_req[1] = 1;
    step();
    chk("t5_junk_ready", 32'(s1_ready), 32'd1);
    step();
    chk("t5_proto", 32'(err_proto), 32'd1);
    chk("t5_junk_gone", 32'(s1_ready), 32'd0);

    // Reset in the middle of a frame
    reset_dut();
    frames_left[0] = 1; len_fixed[0] = 6;
    n = 0;
    while (beat_idx[0] < 2 && n < 40) begin step(); n++; end
    chk("t6_reach_beat2", 32'(beat_idx[0]), 32'd2);
    @(posedge clk); #1; drive();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("t6_rst_tx_start", 32'(tx_start), 32'd0);
    chk("t6_rst_tx_data", tx_data, 32'd0);
    chk("t6_rst_ready0", 32'(s0_ready), 32'd0);
    chk("t6_rst_owner", 32'(owner), 32'd0);
    reset_dut();
    frames_left[1] = 1; len_fixed[1] = 3;
    drain(30, "t6_drain");
    chk("t6_s1_grant", 32'(own_log.size() > 0 ? own_log[0] : 2'b00), 32'h3);

    // Random traffic
    reset_dut();
    for (int seg = 0; seg < 8; seg++) begin
      pv = int'($urandom_range(50, 100));
      pr = int'($urandom_range(30, 100));
      ps = int'($urandom_range(5, 40));
      pj = int'($urandom_range(0, 3));
      for (int c = 0; c < 400; c++) begin
        for (int i = 0; i < 2; i++)
          if (frames_left[i] == 0 && $urandom_range(0, 9) == 0) frames_left[i] = int'($urandom_range(1, 3));
        step();
      end
    end
    pv = 100; pr = 100; ps = 30; pj = 0;
    drain(400, "rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
